scan_chain_controller: RTL and testbench

//  Sequences a CHAIN_LEN-deep mux-D scan chain (scan DFFs: FF1 fed by SI, tail FF drives SO) through load/capture/unload.

---
 rtl/scan_chain_controller.sv | 159 +++++++++++++++
 tb/tb_scan_chain_controller.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_chain_controller.sv
// Scan chain sequencer: shifts each pattern in while the previous response shifts out,
// then captures for one cycle and compares the unloaded response against its expected value.
module scan_chain_controller #(
  parameter int unsigned CHAIN_LEN = 4,
  parameter int unsigned FAIL_W    = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 clr_i,
  input  logic                 pat_valid_i,
  output logic                 pat_ready_o,
  input  logic [CHAIN_LEN-1:0] pat_data_i,
  input  logic [CHAIN_LEN-1:0] exp_data_i,
  output logic                 scan_en_o,
  output logic                 scan_in_o,
  input  logic                 scan_out_i,
  output logic                 resp_valid_o,
  output logic [CHAIN_LEN-1:0] resp_data_o,
  output logic                 resp_fail_o,
  output logic [FAIL_W-1:0]    fail_count_o,
  output logic                 busy_o
);

  localparam int unsigned CntW = $clog2(CHAIN_LEN);

  typedef enum logic [1:0] {StIdle, StShift, StCapture, StUnload} state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [CHAIN_LEN-1:0]   load_q, load_d;
  logic [CHAIN_LEN-1:0]   resp_sh_q, resp_sh_d;
  logic [CHAIN_LEN-1:0]   exp_next_q, exp_next_d;
  logic [CHAIN_LEN-1:0]   exp_cur_q, exp_cur_d;
  logic                   have_resp_q, have_resp_d;
  logic                   resp_valid_q, resp_valid_d;
  logic [CHAIN_LEN-1:0]   resp_data_q, resp_data_d;
  logic                   resp_fail_q, resp_fail_d;
  logic [FAIL_W-1:0]      fail_count_q, fail_count_d;

  logic pat_ready;
  logic accept;
  logic last_bit;
  logic done;

  assign pat_ready = (state_q == StIdle) || (state_q == StCapture);
  assign accept    = pat_valid_i && pat_ready;
  assign last_bit  = (bit_cnt_q == CntW'(CHAIN_LEN - 1));

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    load_d       = load_q;
    resp_sh_d    = resp_sh_q;
    exp_next_d   = exp_next_q;
    exp_cur_d    = exp_cur_q;
    have_resp_d  = have_resp_q;
    resp_valid_d = 1'b0;
    resp_data_d  = resp_data_q;
    resp_fail_d  = resp_fail_q;
    fail_count_d = fail_count_q;
    done         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          load_d      = pat_data_i;
          exp_next_d  = exp_data_i;
          have_resp_d = 1'b0;
          bit_cnt_d   = '0;
          state_d     = StShift;
        end
      end
      StShift: begin
        load_d    = load_q << 1;
        resp_sh_d = {resp_sh_q[CHAIN_LEN-2:0], scan_out_i};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          bit_cnt_d = '0;
          exp_cur_d = exp_next_q;
          state_d   = StCapture;
          done      = have_resp_q;
        end
      end
      StCapture: begin
        have_resp_d = 1'b1;
        bit_cnt_d   = '0;
        if (accept) begin
          load_d     = pat_data_i;
          exp_next_d = exp_data_i;
          state_d    = StShift;
        end else begin
          state_d = StUnload;
        end
      end
      StUnload: begin
        resp_sh_d = {resp_sh_q[CHAIN_LEN-2:0], scan_out_i};
        bit_cnt_d = bit_cnt_q + 1'b1;
        if (last_bit) begin
          bit_cnt_d = '0;
          state_d   = StIdle;
          done      = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Old exp_cur_q still belongs to the response completing on this edge.
    if (done) begin
      resp_valid_d = 1'b1;
      resp_data_d  = resp_sh_d;
      resp_fail_d  = (resp_sh_d != exp_cur_q);
      if (resp_fail_d && (fail_count_q != {FAIL_W{1'b1}})) begin
        fail_count_d = fail_count_q + 1'b1;
      end
    end

    if (clr_i) begin
      fail_count_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      bit_cnt_q    <= '0;
      load_q       <= '0;
      resp_sh_q    <= '0;
      exp_next_q   <= '0;
      exp_cur_q    <= '0;
      have_resp_q  <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= '0;
      resp_fail_q  <= 1'b0;
      fail_count_q <= '0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      load_q       <= load_d;
      resp_sh_q    <= resp_sh_d;
      exp_next_q   <= exp_next_d;
      exp_cur_q    <= exp_cur_d;
      have_resp_q  <= have_resp_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_fail_q  <= resp_fail_d;
      fail_count_q <= fail_count_d;
    end
  end

  assign pat_ready_o  = pat_ready;
  assign scan_en_o    = (state_q == StShift) || (state_q == StUnload);
  assign scan_in_o    = (state_q == StShift) && load_q[CHAIN_LEN-1];
  assign resp_valid_o = resp_valid_q;
  assign resp_data_o  = resp_data_q;
  assign resp_fail_o  = resp_fail_q;
  assign fail_count_o = fail_count_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_scan_chain_controller.sv
// Bench for scan_chain_controller: 4-cell scan chain model, randomized patterns, and a
// reference model of the shift/capture timeline and response scoreboard.
module tb_scan_chain_controller;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       clr;
  logic       pat_valid;
  logic [3:0] pat_data;
  logic [3:0] exp_data;
  logic [3:0] di;
  logic [3:0] chain_q;

  logic       pat_ready, scan_en, scan_in, resp_valid, resp_fail, busy;
  logic [3:0] resp_data;
  logic [7:0] fail_count;
  logic       pat_ready2, scan_en2, scan_in2, resp_valid2, resp_fail2, busy2;
  logic [3:0] resp_data2;
  logic [1:0] fail_count2;

  always #5 clk = ~clk;

  scan_chain_controller #(.CHAIN_LEN(4), .FAIL_W(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .pat_valid_i(pat_valid), .pat_ready_o(pat_ready),
    .pat_data_i(pat_data), .exp_data_i(exp_data), .scan_en_o(scan_en), .scan_in_o(scan_in),
    .scan_out_i(chain_q[3]), .resp_valid_o(resp_valid), .resp_data_o(resp_data),
    .resp_fail_o(resp_fail), .fail_count_o(fail_count), .busy_o(busy)
  );

  // Narrow-counter twin sees identical stimulus; only its fail counter is of interest.
  scan_chain_controller #(.CHAIN_LEN(4), .FAIL_W(2)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .clr_i(clr), .pat_valid_i(pat_valid), .pat_ready_o(pat_ready2),
    .pat_data_i(pat_data), .exp_data_i(exp_data), .scan_en_o(scan_en2), .scan_in_o(scan_in2),
    .scan_out_i(chain_q[3]), .resp_valid_o(resp_valid2), .resp_data_o(resp_data2),
    .resp_fail_o(resp_fail2), .fail_count_o(fail_count2), .busy_o(busy2)
  );

  // Scan chain: bit i is FF(i+1); FF1 takes SI, FF4 drives SO.
  always @(posedge clk) begin
    if (scan_en) chain_q <= {chain_q[2:0], scan_in};
    else         chain_q <= di;
  end

  typedef struct {
    logic [3:0] d;
    logic       f;
    int         t;
  } resp_t;

  int    total = 0;
  int    bad = 0;
  int    fc_model = 0;
  int    fc2_model = 0;
  logic [3:0] pat_a[16], exp_a[16], di_a[16];
  logic  se_tr[$], si_tr[$], busy_tr[$], rdy_tr[$];
  int    fc_tr[$], fc2_tr[$];
  resp_t resp_q[$];

  // Drives n pairs (optionally with random valid gaps) and records per-cycle observations;
  // t=0 is the first sampled cycle. DI follows the most recently accepted pattern.
  task automatic run_stream(input int n, input bit gaps);
    int    idx, t, last_t, acc_idx;
    bit    acc_prev;
    resp_t r;
    idx = 0; t = 0; last_t = 0; acc_idx = 0; acc_prev = 1'b0;
    se_tr.delete(); si_tr.delete(); busy_tr.delete(); rdy_tr.delete();
    fc_tr.delete(); fc2_tr.delete(); resp_q.delete();
    forever begin
      @(negedge clk);
      if (acc_prev) di = di_a[acc_idx];
      se_tr.push_back(scan_en);
      si_tr.push_back(scan_in);
      busy_tr.push_back(busy);
      rdy_tr.push_back(pat_ready);
      fc_tr.push_back(int'(fail_count));
      fc2_tr.push_back(int'(fail_count2));
      if (resp_valid) begin
        r.d = resp_data; r.f = resp_fail; r.t = t;
        resp_q.push_back(r);
        last_t = t;
      end
      if (resp_q.size() == n && t >= last_t + 2) break;
      if (t >= 40 * n + 40) begin
        total++; bad++;
        $display("FAIL run_timeout: responses got=%0d want=%0d", resp_q.size(), n);
        break;
      end
      if (idx < n && (!gaps || $urandom_range(0, 2) != 0)) begin
        pat_valid = 1'b1; pat_data = pat_a[idx]; exp_data = exp_a[idx];
      end else begin
        pat_valid = 1'b0; pat_data = 4'($urandom); exp_data = 4'($urandom);
      end
      acc_prev = pat_valid && pat_ready;
      if (acc_prev) begin
        acc_idx = idx;
        idx++;
      end
      t++;
    end
    pat_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; pat_valid = 1'b0; pat_data = '0; exp_data = '0; di = '0;
    #2;
    total++;
    if (scan_en !== 1'b0 || scan_in !== 1'b0 || pat_ready !== 1'b1 || resp_valid !== 1'b0 ||
        fail_count !== 8'd0 || busy !== 1'b0 || resp_data !== 4'd0 || resp_fail !== 1'b0) begin
      bad++;
      $display("FAIL reset_state: se=%b si=%b rdy=%b rv=%b fc=%0d busy=%b rd=%b rf=%b want 0,0,1,0,0,0,0000,0",
               scan_en, scan_in, pat_ready, resp_valid, fail_count, busy, resp_data, resp_fail);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    fc_model = 0; fc2_model = 0;
  endtask

  task automatic test_single();
    logic e_se, e_si, e_busy, e_rdy;
    int   p, k, n;
    n = 1;
    pat_a[0] = 4'b1010; exp_a[0] = 4'b0110; di_a[0] = 4'b0110;
    run_stream(n, 1'b0);
    for (int t = 0; t <= 5 * n + 5; t++) begin
      if (t == 0 || t == 5 * n + 5) begin
        e_se = 0; e_si = 0; e_busy = 0; e_rdy = 1;
      end else if (t > 5 * n) begin
        e_se = 1; e_si = 0; e_busy = 1; e_rdy = 0;
      end else begin
        p = (t - 1) / 5; k = (t - 1) % 5;
        if (k == 4) begin e_se = 0; e_si = 0; e_busy = 1; e_rdy = 1; end
        else begin e_se = 1; e_si = pat_a[p][3-k]; e_busy = 1; e_rdy = 0; end
      end
      total++;
      if (se_tr[t] !== e_se || si_tr[t] !== e_si || busy_tr[t] !== e_busy || rdy_tr[t] !== e_rdy) begin
        bad++;
        $display("FAIL single_timeline t=%0d: se/si/busy/rdy=%b%b%b%b want %b%b%b%b",
                 t, se_tr[t], si_tr[t], busy_tr[t], rdy_tr[t], e_se, e_si, e_busy, e_rdy);
      end
    end
    total++;
    if (resp_q.size() != n) begin
      bad++; $display("FAIL single_count: got=%0d want=%0d", resp_q.size(), n);
    end
    for (int i = 0; i < resp_q.size(); i++) begin
      if (di_a[i] != exp_a[i]) fc_model = (fc_model < 255) ? fc_model + 1 : 255;
      total++;
      if (resp_q[i].d !== di_a[i] || resp_q[i].f !== (di_a[i] != exp_a[i]) ||
          resp_q[i].t != 10 + 5 * i || fc_tr[resp_q[i].t + 1] != fc_model) begin
        bad++;
        $display("FAIL single_resp: data=%b fail=%b t=%0d fc=%0d want %b %b %0d %0d", resp_q[i].d,
                 resp_q[i].f, resp_q[i].t, fc_tr[resp_q[i].t + 1], di_a[i], di_a[i] != exp_a[i],
                 10 + 5 * i, fc_model);
      end
    end
  endtask

  task automatic test_mismatch();
    pat_a[0] = 4'b0000; exp_a[0] = 4'b0110; di_a[0] = 4'b0111;
    run_stream(1, 1'b0);
    fc_model = 1; fc2_model = 1;
    total++;
    if (resp_q.size() != 1 || resp_q[0].d !== 4'b0111 || resp_q[0].f !== 1'b1 ||
        fc_tr[resp_q[0].t + 1] != fc_model || fc2_tr[resp_q[0].t + 1] != fc2_model) begin
      bad++;
      $display("FAIL mismatch_resp: n=%0d data=%b fail=%b fc=%0d fc2=%0d want 1 0111 1 1 1",
               resp_q.size(), resp_q[0].d, resp_q[0].f, fc_tr[resp_q[0].t + 1],
               fc2_tr[resp_q[0].t + 1]);
    end
  endtask

  task automatic test_abort();
    int pulses;
    @(negedge clk);
    pat_valid = 1'b1; pat_data = 4'b1110; exp_data = 4'b0000;
    @(negedge clk);
    pat_valid = 1'b0;
    total++;
    if (scan_en !== 1'b1 || scan_in !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("FAIL abort_shift_start: se=%b si=%b busy=%b want 111", scan_en, scan_in, busy);
    end
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    fc_model = 0; fc2_model = 0;
    total++;
    if (scan_en !== 1'b0 || scan_in !== 1'b0 || pat_ready !== 1'b1 || resp_valid !== 1'b0 ||
        fail_count !== 8'd0 || fail_count2 !== 2'd0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: se=%b si=%b rdy=%b rv=%b fc=%0d fc2=%0d busy=%b want 0,0,1,0,0,0,0",
               scan_en, scan_in, pat_ready, resp_valid, fail_count, fail_count2, busy);
    end
    @(negedge clk);
    rst_n = 1'b1;
    pulses = 0;
    repeat (25) begin
      @(negedge clk);
      if (resp_valid) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++; $display("FAIL abort_no_resp: pulses=%0d want=0", pulses);
    end
    pat_a[0] = 4'($urandom); exp_a[0] = 4'($urandom); di_a[0] = exp_a[0];
    run_stream(1, 1'b0);
    total++;
    if (resp_q.size() != 1 || resp_q[0].d !== di_a[0] || resp_q[0].f !== 1'b0 ||
        resp_q[0].t != 10 || fc_tr[resp_q[0].t + 1] != 0) begin
      bad++;
      $display("FAIL abort_restart: n=%0d data=%b fail=%b t=%0d want 1 %b 0 10",
               resp_q.size(), resp_q[0].d, resp_q[0].f, resp_q[0].t, di_a[0]);
    end
  endtask

  task automatic test_stream();
    logic e_se, e_si, e_busy, e_rdy;
    int   p, k, n;
    n = 3;
    di_a[0] = 4'b0001; di_a[1] = 4'b0010; di_a[2] = 4'b0100;
    for (int i = 0; i < n; i++) begin
      pat_a[i] = 4'($urandom); exp_a[i] = di_a[i];
    end
    run_stream(n, 1'b0);
    for (int t = 0; t <= 5 * n + 5; t++) begin
      if (t == 0 || t == 5 * n + 5) begin
        e_se = 0; e_si = 0; e_busy = 0; e_rdy = 1;
      end else if (t > 5 * n) begin
        e_se = 1; e_si = 0; e_busy = 1; e_rdy = 0;
      end else begin
        p = (t - 1) / 5; k = (t - 1) % 5;
        if (k == 4) begin e_se = 0; e_si = 0; e_busy = 1; e_rdy = 1; end
        else begin e_se = 1; e_si = pat_a[p][3-k]; e_busy = 1; e_rdy = 0; end
      end
      total++;
      if (se_tr[t] !== e_se || si_tr[t] !== e_si || busy_tr[t] !== e_busy || rdy_tr[t] !== e_rdy) begin
        bad++;
        $display("FAIL stream_timeline t=%0d: se/si/busy/rdy=%b%b%b%b want %b%b%b%b",
                 t, se_tr[t], si_tr[t], busy_tr[t], rdy_tr[t], e_se, e_si, e_busy, e_rdy);
      end
    end
    total++;
    if (resp_q.size() != n) begin
      bad++; $display("FAIL stream_count: got=%0d want=%0d", resp_q.size(), n);
    end
    for (int i = 0; i < resp_q.size(); i++) begin
      total++;
      if (resp_q[i].d !== di_a[i] || resp_q[i].f !== 1'b0 || resp_q[i].t != 10 + 5 * i ||
          fc_tr[resp_q[i].t + 1] != fc_model) begin
        bad++;
        $display("FAIL stream_resp%0d: data=%b fail=%b t=%0d fc=%0d want %b 0 %0d %0d", i,
                 resp_q[i].d, resp_q[i].f, resp_q[i].t, fc_tr[resp_q[i].t + 1], di_a[i],
                 10 + 5 * i, fc_model);
      end
    end
  endtask

  task automatic test_saturate();
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    fc_model = 0; fc2_model = 0;
    total++;
    if (fail_count !== 8'd0 || fail_count2 !== 2'd0) begin
      bad++; $display("FAIL sat_initial_clr: fc=%0d fc2=%0d want 0 0", fail_count, fail_count2);
    end
    for (int i = 0; i < 5; i++) begin
      pat_a[i] = 4'($urandom); exp_a[i] = 4'($urandom);
      di_a[i] = exp_a[i] ^ 4'($urandom_range(1, 15));
    end
    run_stream(5, 1'b0);
    for (int i = 0; i < resp_q.size(); i++) begin
      fc_model = fc_model + 1;
      fc2_model = (fc2_model < 3) ? fc2_model + 1 : 3;
      total++;
      if (resp_q[i].d !== di_a[i] || resp_q[i].f !== 1'b1 || fc_tr[resp_q[i].t + 1] != fc_model ||
          fc2_tr[resp_q[i].t + 1] != fc2_model) begin
        bad++;
        $display("FAIL sat_resp%0d: data=%b fail=%b fc=%0d fc2=%0d want %b 1 %0d %0d", i,
                 resp_q[i].d, resp_q[i].f, fc_tr[resp_q[i].t + 1], fc2_tr[resp_q[i].t + 1],
                 di_a[i], fc_model, fc2_model);
      end
    end
    total++;
    if (resp_q.size() != 5) begin
      bad++; $display("FAIL sat_count: got=%0d want=5", resp_q.size());
    end
    @(negedge clk); clr = 1'b1;
    @(negedge clk); clr = 1'b0;
    fc_model = 0; fc2_model = 0;
    total++;
    if (fail_count !== 8'd0 || fail_count2 !== 2'd0) begin
      bad++; $display("FAIL sat_clr: fc=%0d fc2=%0d want 0 0", fail_count, fail_count2);
    end
    // A failing response arriving while clr is held must not bump the count.
    pat_a[0] = 4'($urandom); exp_a[0] = 4'b1100; di_a[0] = 4'b0011;
    clr = 1'b1;
    run_stream(1, 1'b0);
    total++;
    if (resp_q.size() != 1 || resp_q[0].f !== 1'b1 || fail_count !== 8'd0 || fail_count2 !== 2'd0) begin
      bad++;
      $display("FAIL sat_clr_priority: n=%0d fail=%b fc=%0d fc2=%0d want 1 1 0 0",
               resp_q.size(), resp_q[0].f, fail_count, fail_count2);
    end
    @(negedge clk); clr = 1'b0;
  endtask

  task automatic test_random();
    int  n;
    bit  fl;
    for (int round = 0; round < 2; round++) begin
      n = (round == 0) ? 10 : 7;
      for (int i = 0; i < n; i++) begin
        pat_a[i] = 4'($urandom); exp_a[i] = 4'($urandom);
        di_a[i] = ($urandom_range(0, 1) == 0) ? exp_a[i] : exp_a[i] ^ 4'($urandom_range(1, 15));
      end
      run_stream(n, round == 0);
      total++;
      if (resp_q.size() != n) begin
        bad++; $display("FAIL rand%0d_count: got=%0d want=%0d", round, resp_q.size(), n);
      end
      for (int i = 0; i < resp_q.size(); i++) begin
        fl = (di_a[i] != exp_a[i]);
        if (fl) begin
          fc_model = (fc_model < 255) ? fc_model + 1 : 255;
          fc2_model = (fc2_model < 3) ? fc2_model + 1 : 3;
        end
        total++;
        if (resp_q[i].d !== di_a[i] || resp_q[i].f !== fl || fc_tr[resp_q[i].t + 1] != fc_model ||
            fc2_tr[resp_q[i].t + 1] != fc2_model || (round == 1 && resp_q[i].t != 10 + 5 * i)) begin
          bad++;
          $display("FAIL rand%0d_resp%0d: data=%b fail=%b t=%0d fc=%0d fc2=%0d want %b %b fc %0d fc2 %0d",
                   round, i, resp_q[i].d, resp_q[i].f, resp_q[i].t, fc_tr[resp_q[i].t + 1],
                   fc2_tr[resp_q[i].t + 1], di_a[i], fl, fc_model, fc2_model);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_mismatch();
    test_abort();
    test_stream();
    test_saturate();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
